// File: rtl/exec_flags_wb.sv
// Writeback/flags stage: two-entry skid buffer toward the register file plus the architectural NZCV flags register.
// Optional macro FLAGS_BYPASS_EN forwards same-cycle flag updates combinationally onto flags_o.
module exec_flags_wb #(
  parameter int W_OPR   = 16,
  parameter int W_FLAGS = 4,
  parameter int W_RADDR = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [W_OPR-1:0]   result_i,
  input  logic [W_FLAGS-1:0] flags_i,
  input  logic               flags_we_i,
  input  logic               rd_we_i,
  input  logic [W_RADDR-1:0] rd_addr_i,
  input  logic               flush_i,
  input  logic               flags_set_i,
  input  logic [W_FLAGS-1:0] flags_set_val_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [W_OPR-1:0]   wb_data_o,
  output logic [W_RADDR-1:0] wb_addr_o,
  output logic               wb_we_o,
  output logic [W_FLAGS-1:0] flags_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]         count;
  logic [W_OPR-1:0]   head_data;
  logic [W_RADDR-1:0] head_addr;
  logic               head_we;
  logic [W_OPR-1:0]   tail_data;
  logic [W_RADDR-1:0] tail_addr;
  logic               tail_we;
  logic [W_FLAGS-1:0] flags_q;
  logic               accept;
  logic               drain;

  // ready depends only on registered occupancy so the execute unit never sees a path from wb_ready_i
  assign ready_o    = (count != FULL);
  assign wb_valid_o = (count != EMPTY);
  assign accept     = valid_i & ready_o & ~flush_i;
  assign drain      = wb_valid_o & wb_ready_i;

  assign wb_data_o = head_data;
  assign wb_addr_o = head_addr;
  assign wb_we_o   = head_we;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count     <= EMPTY;
      head_data <= '0;
      head_addr <= '0;
      head_we   <= 1'b0;
      tail_data <= '0;
      tail_addr <= '0;
      tail_we   <= 1'b0;
    end else if (flush_i) begin
      count <= EMPTY;
    end else begin
      case (count)
        EMPTY: begin
          if (accept) begin
            head_data <= result_i;
            head_addr <= rd_addr_i;
            head_we   <= rd_we_i;
            count     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_data <= result_i;
            head_addr <= rd_addr_i;
            head_we   <= rd_we_i;
          end else if (accept) begin
            tail_data <= result_i;
            tail_addr <= rd_addr_i;
            tail_we   <= rd_we_i;
            count     <= FULL;
          end else if (drain) begin
            count <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            head_data <= tail_data;
            head_addr <= tail_addr;
            head_we   <= tail_we;
            count     <= ONE;
          end
        end
        default: count <= EMPTY;
      endcase
    end
  end

  // Flags retire at accept time, never waiting for the register-file write
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      flags_q <= '0;
    end else if (flags_set_i) begin
      flags_q <= flags_set_val_i;
    end else if (accept && flags_we_i) begin
      flags_q <= flags_i;
    end
  end

`ifdef FLAGS_BYPASS_EN
  always_comb begin
    flags_o = flags_q;
    if (flags_set_i) begin
      flags_o = flags_set_val_i;
    end else if (accept && flags_we_i) begin
      flags_o = flags_i;
    end
  end
`else
  assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_exec_flags_wb.sv
// Directed self-checking bench for exec_flags_wb: reset, carry chain, backpressure, flush, flag priority, mid-run reset.
// Pre-edge flags_o expectations follow FLAGS_BYPASS_EN when the bench is built with it.
module tb_exec_flags_wb;

`ifdef FLAGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        flags_we;
  logic        rd_we;
  logic [3:0]  rd_addr;
  logic        flush;
  logic        flags_set;
  logic [3:0]  flags_set_val;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_addr;
  logic        wb_we;
  logic [3:0]  flags_out;

  int checks = 0;
  int errors = 0;

  exec_flags_wb #(.W_OPR(16), .W_FLAGS(4), .W_RADDR(4)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .valid_i         (valid),
    .ready_o         (ready),
    .result_i        (result),
    .flags_i         (flags),
    .flags_we_i      (flags_we),
    .rd_we_i         (rd_we),
    .rd_addr_i       (rd_addr),
    .flush_i         (flush),
    .flags_set_i     (flags_set),
    .flags_set_val_i (flags_set_val),
    .wb_valid_o      (wb_valid),
    .wb_ready_i      (wb_ready),
    .wb_data_o       (wb_data),
    .wb_addr_o       (wb_addr),
    .wb_we_o         (wb_we),
    .flags_o         (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [15:0] r, input logic [3:0] f,
                               input logic fwe, input logic rwe, input logic [3:0] ra,
                               input logic fl, input logic wbr);
    valid    = v;
    result   = r;
    flags    = f;
    flags_we = fwe;
    rd_we    = rwe;
    rd_addr  = ra;
    flush    = fl;
    wb_ready = wbr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    flags_set     = 1'b0;
    flags_set_val = 4'h0;
    applyStimulus(1'b1, 16'h1234, 4'hF, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst_flags", {28'd0, flags_out}, 32'h0);
    checkOutput("rst_wb_data", {16'd0, wb_data}, 32'h0);
    checkOutput("rst_wb_addr", {28'd0, wb_addr}, 32'h0);
    checkOutput("rst_wb_we", {31'd0, wb_we}, 32'd0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checkOutput("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("post_rst_flags", {28'd0, flags_out}, 32'h0);

    // Carry chain: two back-to-back flag-writing beats
    applyStimulus(1'b1, 16'h0000, 4'b0011, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1);
    checkOutput("carry_pre1_flags", {28'd0, flags_out}, BYPASS ? 32'h3 : 32'h0);
    tick();
    checkOutput("carry_wb_valid1", {31'd0, wb_valid}, 32'd1);
    checkOutput("carry_wb_data1", {16'd0, wb_data}, 32'h0000);
    checkOutput("carry_wb_addr1", {28'd0, wb_addr}, 32'h1);
    checkOutput("carry_wb_we1", {31'd0, wb_we}, 32'd1);
    applyStimulus(1'b1, 16'h0001, 4'b0000, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1);
    checkOutput("carry_flags_after_first", {28'd0, flags_out}, BYPASS ? 32'h0 : 32'h3);
    tick();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("carry_wb_data2", {16'd0, wb_data}, 32'h0001);
    checkOutput("carry_wb_addr2", {28'd0, wb_addr}, 32'h2);
    checkOutput("carry_flags_after_second", {28'd0, flags_out}, 32'h0);
    tick();
    checkOutput("carry_drained", {31'd0, wb_valid}, 32'd0);

    // Backpressure: 1111..4444 with the register file stalled
    applyStimulus(1'b1, 16'h1111, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
    tick();
    checkOutput("bp_data1", {16'd0, wb_data}, 32'h1111);
    checkOutput("bp_ready1", {31'd0, ready}, 32'd1);
    applyStimulus(1'b1, 16'h2222, 4'h0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
    tick();
    checkOutput("bp_ready_full", {31'd0, ready}, 32'd0);
    checkOutput("bp_data_hold1", {16'd0, wb_data}, 32'h1111);
    applyStimulus(1'b1, 16'h3333, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
    tick();
    checkOutput("bp_ready_full2", {31'd0, ready}, 32'd0);
    checkOutput("bp_data_hold2", {16'd0, wb_data}, 32'h1111);
    checkOutput("bp_valid_hold", {31'd0, wb_valid}, 32'd1);
    applyStimulus(1'b1, 16'h3333, 4'h0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1);
    tick();
    checkOutput("bp_data2", {16'd0, wb_data}, 32'h2222);
    checkOutput("bp_addr2", {28'd0, wb_addr}, 32'h4);
    checkOutput("bp_ready_reopen", {31'd0, ready}, 32'd1);
    tick();
    checkOutput("bp_data3", {16'd0, wb_data}, 32'h3333);
    checkOutput("bp_we3", {31'd0, wb_we}, 32'd0);
    applyStimulus(1'b1, 16'h4444, 4'h0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b1);
    tick();
    checkOutput("bp_data4", {16'd0, wb_data}, 32'h4444);
    checkOutput("bp_we4", {31'd0, wb_we}, 32'd1);
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checkOutput("bp_no_dup", {31'd0, wb_valid}, 32'd0);

    // Flush a full buffer while an incoming flag-writing beat is dropped
    applyStimulus(1'b1, 16'hAAAA, 4'h0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hBBBB, 4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
    tick();
    checkOutput("flush_full_ready", {31'd0, ready}, 32'd0);
    applyStimulus(1'b1, 16'hCCCC, 4'b1000, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0);
    checkOutput("flush_pre_flags", {28'd0, flags_out}, 32'h0);
    tick();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("flush_ready", {31'd0, ready}, 32'd1);
    checkOutput("flush_flags", {28'd0, flags_out}, 32'h0);

    // flags_set wins over an accepted flag-writing beat
    flags_set     = 1'b1;
    flags_set_val = 4'b0101;
    applyStimulus(1'b1, 16'hDDDD, 4'b1010, 1'b1, 1'b1, 4'hA, 1'b0, 1'b1);
    checkOutput("prio_pre_flags", {28'd0, flags_out}, BYPASS ? 32'h5 : 32'h0);
    tick();
    flags_set = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("prio_flags", {28'd0, flags_out}, 32'h5);
    checkOutput("prio_beat_kept", {16'd0, wb_data}, 32'hDDDD);
    tick();
    checkOutput("prio_drained", {31'd0, wb_valid}, 32'd0);

    // A beat without flags_we must leave the flags alone
    applyStimulus(1'b1, 16'hEEEE, 4'b1111, 1'b0, 1'b1, 4'hB, 1'b0, 1'b1);
    checkOutput("nofwe_pre_flags", {28'd0, flags_out}, 32'h5);
    tick();
    applyStimulus(1'b1, 16'h0F0F, 4'b0001, 1'b1, 1'b1, 4'hC, 1'b0, 1'b1);
    checkOutput("nofwe_flags", {28'd0, flags_out}, BYPASS ? 32'h1 : 32'h5);
    tick();
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("fwe_flags", {28'd0, flags_out}, 32'h1);
    checkOutput("fwe_wb_data", {16'd0, wb_data}, 32'h0F0F);
    tick();

    // Reset mid-operation beats flush and flags_set
    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b1, 4'hD, 1'b0, 1'b0);
    tick();
    rst_n         = 1'b0;
    flags_set     = 1'b1;
    flags_set_val = 4'b1010;
    applyStimulus(1'b1, 16'h5678, 4'b1111, 1'b1, 1'b1, 4'hE, 1'b1, 1'b0);
    tick();
    rst_n     = 1'b1;
    flags_set = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("midrst_ready", {31'd0, ready}, 32'd1);
    checkOutput("midrst_flags", {28'd0, flags_out}, 32'h0);
    checkOutput("midrst_wb_data", {16'd0, wb_data}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
